// File: rtl/caliptra_verilated_pkg.sv
// Shared types and defaults for the verilated-model generic-output capture blocks.
// The entry layout is a macro so each instance can size it from its own parameters.
`ifndef CALIPTRA_GEN_OUT_ENTRY_T
`define CALIPTRA_GEN_OUT_ENTRY_T(CW, DW, TW) \
  struct packed { \
    logic [(CW)-1:0] ch; \
    logic [(DW)-1:0] data; \
    logic [(TW)-1:0] ts; \
  }
`endif

package caliptra_verilated_pkg;

  localparam int GEN_OUT_DEFAULT_DEPTH = 16;

  // Default-width entry (2 channels, 32-bit data, 32-bit timestamp).
  typedef `CALIPTRA_GEN_OUT_ENTRY_T(1, 32, 32) gen_out_entry_t;

  // Index width for n items, never narrower than one bit.
  function automatic int gen_out_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/caliptra_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, searching upward from the pointer,
// which moves to one past the granted requester.
module caliptra_rr_arbiter
  import caliptra_verilated_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = gen_out_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               j;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = IDX_W'(j);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (|grant) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/caliptra_verilated_gen_out_capture.sv
// Multi-channel capture of generic-output load events: per-channel staging with an
// optional change-only filter, round-robin into a time-stamped FWFT FIFO, drop accounting.
module caliptra_verilated_gen_out_capture
  import caliptra_verilated_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = GEN_OUT_DEFAULT_DEPTH,
  parameter int TS_W   = 32,
  parameter int DROP_W = 16,
  localparam int CH_W  = gen_out_idx_w(NUM_CH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           cptra_rst_b,
  input  logic [NUM_CH-1:0]              load_en,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  load_data,
  input  logic                           cap_mode,
  input  logic                           pop,
  output logic                           rd_valid,
  output logic [CH_W-1:0]                rd_ch,
  output logic [DATA_W-1:0]              rd_data,
  output logic [TS_W-1:0]                rd_ts,
  output logic [AW:0]                    count,
  output logic                           overflow,
  output logic [DROP_W-1:0]              drop_cnt,
  input  logic                           overflow_clr
);

  typedef `CALIPTRA_GEN_OUT_ENTRY_T(CH_W, DATA_W, TS_W) entry_t;

  localparam int NDW = $clog2(NUM_CH + 1);

  logic [TS_W-1:0]               ts_q;
  logic [NUM_CH-1:0]             stg_valid;
  logic [NUM_CH-1:0][DATA_W-1:0] stg_data;
  logic [NUM_CH-1:0][TS_W-1:0]   stg_ts;
  logic [NUM_CH-1:0][DATA_W-1:0] last_val;
  logic [NUM_CH-1:0]             qual, stg_wr, drop, grant;
  logic [CH_W-1:0]               grant_idx;
  logic [NDW-1:0]                ndrop;
  logic [DROP_W-1:0]             drop_base;
  logic [DROP_W:0]               drop_sum;

  entry_t     mem [DEPTH];
  entry_t     head, push_entry;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, push, pop_eff;

  // A stage accepts a new event if empty or being drained by this cycle's grant.
  always_comb begin
    qual   = '0;
    stg_wr = '0;
    drop   = '0;
    ndrop  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      qual[c]   = load_en[c] && (!cap_mode || (load_data[c] != last_val[c]));
      stg_wr[c] = qual[c] && (!stg_valid[c] || grant[c]);
      drop[c]   = qual[c] && !stg_wr[c];
      if (drop[c]) ndrop = ndrop + NDW'(1);
    end
  end

  assign drop_base = overflow_clr ? '0 : drop_cnt;
  assign drop_sum  = {1'b0, drop_base} + (DROP_W + 1)'(ndrop);

  caliptra_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .rst_n     (cptra_rst_b),
    .req       (stg_valid),
    .en        (!full),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    push_entry      = '0;
    push_entry.ch   = grant_idx;
    push_entry.data = stg_data[grant_idx];
    push_entry.ts   = stg_ts[grant_idx];
  end

  assign push     = |grant;
  assign rd_valid = (wr_ptr != rd_ptr);
  assign pop_eff  = pop && rd_valid;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_ch    = rd_valid ? head.ch   : '0;
  assign rd_data  = rd_valid ? head.data : '0;
  assign rd_ts    = rd_valid ? head.ts   : '0;

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      ts_q      <= '0;
      stg_valid <= '0;
      stg_data  <= '0;
      stg_ts    <= '0;
      last_val  <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (stg_wr[c]) begin
          stg_valid[c] <= 1'b1;
          stg_data[c]  <= load_data[c];
          stg_ts[c]    <= ts_q;
        end else if (grant[c]) begin
          stg_valid[c] <= 1'b0;
        end
        if (load_en[c]) last_val[c] <= load_data[c];
      end
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count from zero.
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (|drop) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + (AW + 1)'(1);
      end
      if (pop_eff) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_caliptra_verilated_gen_out_capture.sv
// Bench for the generic-output capture buffer: scripted vector table, corner-case
// sequences and randomized traffic against a queue-level reference model.
module tb_caliptra_verilated_gen_out_capture;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 32;
  localparam int DROP_W = 16;
  localparam int EW     = 1 + DATA_W + TS_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          cptra_rst_b;
  logic [NUM_CH-1:0]             load_en;
  logic [NUM_CH-1:0][DATA_W-1:0] load_data;
  logic                          cap_mode, pop, overflow_clr;
  logic                          rd_valid, overflow;
  logic [0:0]                    rd_ch;
  logic [DATA_W-1:0]             rd_data;
  logic [TS_W-1:0]               rd_ts;
  logic [4:0]                    count;
  logic [DROP_W-1:0]             drop_cnt;

  caliptra_verilated_gen_out_capture #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
  ) dut (
    .clk          (clk),
    .cptra_rst_b  (cptra_rst_b),
    .load_en      (load_en),
    .load_data    (load_data),
    .cap_mode     (cap_mode),
    .pop          (pop),
    .rd_valid     (rd_valid),
    .rd_ch        (rd_ch),
    .rd_data      (rd_data),
    .rd_ts        (rd_ts),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .overflow_clr (overflow_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  logic [NUM_CH-1:0] m_sv;
  logic [31:0]       m_sd[NUM_CH];
  logic [31:0]       m_st[NUM_CH];
  logic [31:0]       m_last[NUM_CH];
  int                m_rr;
  logic [31:0]       m_ts;
  logic              m_ovf;
  int                m_dcnt;

  task automatic model_reset();
    exp_q.delete();
    m_sv = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_sd[c] = '0; m_st[c] = '0; m_last[c] = '0;
    end
    m_rr = 0; m_ts = '0; m_ovf = 1'b0; m_dcnt = 0;
  endtask

  // One clock of the buffer, reading the inputs the bench is driving this cycle.
  task automatic model_step();
    int g;
    int c;
    int nd;
    logic [EW-1:0] ge;
    logic [EW-1:0] dummy;
    g = -1;
    ge = '0;
    if (exp_q.size() < DEPTH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        c = (m_rr + i) % NUM_CH;
        if (g < 0 && m_sv[c]) g = c;
      end
    end
    if (g >= 0) ge = {1'(g), m_sd[g], m_st[g]};
    if (pop && exp_q.size() > 0) dummy = exp_q.pop_front();
    if (g >= 0) begin
      exp_q.push_back(ge);
      m_sv[g] = 1'b0;
      m_rr = (g + 1) % NUM_CH;
    end
    nd = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (load_en[k] && (!cap_mode || load_data[k] != m_last[k])) begin
        if (!m_sv[k]) begin
          m_sv[k] = 1'b1; m_sd[k] = load_data[k]; m_st[k] = m_ts;
        end else begin
          nd++;
        end
      end
      if (load_en[k]) m_last[k] = load_data[k];
    end
    if (nd > 0) begin
      m_ovf = 1'b1;
      m_dcnt = (overflow_clr ? 0 : m_dcnt) + nd;
      if (m_dcnt > 65535) m_dcnt = 65535;
    end else if (overflow_clr) begin
      m_ovf = 1'b0; m_dcnt = 0;
    end
    m_ts = m_ts + 32'd1;
  endtask

  task automatic model_check();
    logic [EW-1:0] e;
    chk("mdl_rd_valid", rd_valid, exp_q.size() > 0);
    chk("mdl_count", count, exp_q.size());
    chk("mdl_overflow", overflow, m_ovf);
    chk("mdl_drop_cnt", drop_cnt, m_dcnt);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("mdl_rd_ch", rd_ch, e[EW-1]);
      chk("mdl_rd_data", rd_data, e[63:32]);
      chk("mdl_rd_ts", rd_ts, e[31:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1,
                       input logic mode, input logic p, input logic clr);
    load_en = en; load_data[0] = d0; load_data[1] = d1;
    cap_mode = mode; pop = p; overflow_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle(input logic p);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, p, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_ch"}, rd_ch, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_ts"}, rd_ts, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  task automatic do_reset();
    cptra_rst_b = 1'b0;
    load_en = '0; load_data = '0; cap_mode = 1'b0; pop = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    model_reset();
    cptra_rst_b = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]  en;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        mode;
    logic        p;
    logic        ev;
    logic        ech;
    logic [31:0] edata;
    logic [31:0] ets;
    logic [4:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1,
                              input logic mode, input logic p, input logic ev, input logic ech,
                              input logic [31:0] edata, input logic [31:0] ets, input logic [4:0] ecnt);
    vec_t v;
    v.en = en; v.d0 = d0; v.d1 = d1; v.mode = mode; v.p = p;
    v.ev = ev; v.ech = ech; v.edata = edata; v.ets = ets; v.ecnt = ecnt;
    return v;
  endfunction

  logic [1:0]  r_en;
  logic [31:0] r_d0, r_d1;
  int          pct;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    // Row i runs in the cycle whose timestamp is i (table starts right after reset).
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b01, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 32'd10, 5'd1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b10, 32'h0, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 32'd13, 5'd1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b11, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 32'd16, 5'd1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 32'd16, 5'd2));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 32'd16, 5'd1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b10, 32'h0, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b10, 32'h0, 32'h5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 32'd21, 5'd1));
    vecs.push_back(mk(2'b10, 32'h0, 32'h7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 32'd21, 5'd1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 32'd21, 5'd2));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7, 32'd23, 5'd1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b01, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0));

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].en, vecs[i].d0, vecs[i].d1, vecs[i].mode, vecs[i].p, 1'b0);
      chk($sformatf("tbl%0d_valid", i), rd_valid, vecs[i].ev);
      chk($sformatf("tbl%0d_count", i), count, vecs[i].ecnt);
      if (vecs[i].ev) begin
        chk($sformatf("tbl%0d_ch", i), rd_ch, vecs[i].ech);
        chk($sformatf("tbl%0d_data", i), rd_data, vecs[i].edata);
        chk($sformatf("tbl%0d_ts", i), rd_ts, vecs[i].ets);
      end
    end
    chk("tbl_drop_cnt", drop_cnt, 0);

    // Overflow: ch0 every cycle for 20 cycles, nothing popped.
    for (int k = 0; k < 20; k++) cycle(2'b01, 32'h100 + 32'(k), 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_cnt", drop_cnt, 3);
    chk("ovf_head", rd_data, 32'h100);

    // Full: pop plus a new load in one cycle grants nothing.
    cycle(2'b10, 32'h0, 32'h55, 1'b0, 1'b1, 1'b0);
    chk("full_pop_count", count, 15);
    idle(1'b0);
    chk("full_refill_count", count, 16);
    cycle(2'b01, 32'h999, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_cnt", drop_cnt, 1);
    chk("clr_drop_ovf", overflow, 1);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_only_cnt", drop_cnt, 0);
    chk("clr_only_ovf", overflow, 0);
    chk("clr_keeps_fifo", count, 16);
    for (int k = 0; k < 40 && rd_valid; k++) idle(1'b1);
    chk("drain_count", count, 0);

    // Asynchronous reset with entries and stages live.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(2'b01, 32'h200 + 32'(k), 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", count, 5);
    #2;
    cptra_rst_b = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    cptra_rst_b = 1'b1;
    cycle(2'b10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("zero_first_load", count, 0);
    cycle(2'b01, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("post_rst_valid", rd_valid, 1);
    chk("post_rst_data", rd_data, 32'h77);
    chk("post_rst_ts", rd_ts, 32'd2);
    idle(1'b1);

    // Randomized traffic at three drain rates.
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 15 : (ph == 1) ? 55 : 90;
      for (int k = 0; k < 1000; k++) begin
        r_en = 2'($urandom_range(0, 3));
        r_d0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
        r_d1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
        cycle(r_en, r_d0, r_d1, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < pct), ($urandom_range(0, 63) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
